mtime_bus_master: RTL
=====================

// Module: mtime_bus_master
// PURPOSE
//  Bus initiator that drives the timer's req/addr/we/wdata/rdata/ready slave port.
//  It performs tear-free 64-bit accesses on the 32-bit bus:
//  - mtime reads use a hi-lo-hi sequence with retry.
//  - mtimecmp writes use a glitch-free lo/hi/lo sequence.
//  It sits between a command source (boot sequencer or debug path) and the timer.
// PARAMETERS
//  MTIME_ADDR    32'h0200BFF8  base of mtime; hi word at +4
//  MTIMECMP_ADDR 32'h02004000  base of mtimecmp; hi word at +4
//  MAX_RETRY     4             hi-lo-hi re-read attempts before an error is flagged
//  TIMEOUT       16            cycles without ready before a transfer is aborted
// PORTS
//  clk        in   1   clock, all logic on rising edge
//  rst        in   1   asynchronous, active-high reset
//  cmd_valid  in   1   command request
//  cmd_ready  out  1   high when idle; command accepted on cmd_valid && cmd_ready
//  cmd_op     in   1   0 = read mtime, 1 = write mtimecmp
//  cmd_wdata  in   64  mtimecmp value; sampled at accept
//  rsp_valid  out  1   one-cycle pulse when a command completes
//  rsp_data   out  64  mtime read result; held until the next rsp_valid
//  rsp_err    out  1   timeout or retry exhaustion; valid with rsp_valid, held with rsp_data
//  req        out  1   bus request
//  addr       out  32  bus address
//  we         out  1   bus write enable
//  wdata      out  32  bus write data
//  rdata      in   32  bus read data; sampled on the edge where ready=1
//  ready      in   1   bus transfer complete (may be combinational from req)
// BEHAVIOUR
//  Reset (async, any state): FSM to IDLE.
//   - req, we, rsp_valid, rsp_err = 0; addr, wdata, rsp_data = 0.
//   - Retry and timeout counters = 0; cmd_ready = 1 (decoded from IDLE).
//  Bus handshake:
//   - req/addr/we/wdata are registered and stay stable while req=1 && ready=0.
//   - A transfer completes on an edge with req && ready.
//   - The next transfer's addr/we/wdata are presented the following cycle with req kept high.
//   - With a zero-wait slave, the bus runs one transfer per cycle.
//  FSM states: IDLE, RD_HI1, RD_LO, RD_HI2, WR_LO_MAX, WR_HI, WR_LO.
//  Read path, on accept with op=0:
//   - RD_HI1 at MTIME_ADDR+4, then RD_LO at MTIME_ADDR, then RD_HI2 at MTIME_ADDR+4.
//   - hi1 and lo are captured into internal registers.
//   - If hi2 == hi1: rsp_data = {hi1, lo}, err = 0, go to IDLE.
//   - If hi2 != hi1 and retry < MAX_RETRY: hi1 <= hi2, retry++, go to RD_LO.
//   - If hi2 != hi1 and retry == MAX_RETRY: rsp_data = {hi2, lo}, err = 1, go to IDLE.
//  Write path, on accept with op=1 (we=1 for all three):
//   - WR_LO_MAX writes 32'hFFFFFFFF to MTIMECMP_ADDR.
//   - WR_HI writes cmd_wdata[63:32] to MTIMECMP_ADDR+4.
//   - WR_LO writes cmd_wdata[31:0] to MTIMECMP_ADDR, then go to IDLE.
//   - This order guarantees no spurious timer_irq from a half-written compare value.
//  Timeout:
//   - The counter clears at each transfer start and increments while req && !ready.
//   - At TIMEOUT: drop req next cycle, abort the sequence, pulse rsp_valid with err=1.
//   - rsp_data is unchanged on a timeout.
//  Latency (zero-wait slave):
//   - Read: accept at edge E0, bus cycles 1-3, rsp_valid and cmd_ready high in cycle 4.
//   - Each retry adds 2 cycles; a write also completes in cycle 4.
//  Boundaries:
//   - cmd_valid while busy is ignored (cmd_ready=0).
//   - A new command is accepted in the same cycle as rsp_valid.
//   - The retry counter clears at each accept.
//   - lo wrapping FFFFFFFF->0 between reads is caught by the hi compare.
//   - Reset mid-sequence drops req immediately with no response pulse.
// TESTING
//  1. Read, slave mtime = 64'h5_FFFFFF00 static -> 3 transfers (0x0200BFFC, 0x0200BFF8, 0x0200BFFC),
//     rsp_valid in cycle 4, rsp_data = 64'h5_FFFFFF00, rsp_err = 0.
//  2. Read with slave hi changing: hi1 = 5, lo = 2, hi2 = 6, lo = 3, hi = 6 -> 5 transfers,
//     rsp_data = 64'h6_00000003, rsp_err = 0, rsp_valid in cycle 6.
//  3. Write 64'h1_00000010 -> writes 0xFFFFFFFF@0x02004000, 0x1@0x02004004, 0x10@0x02004000,
//     we = 1 throughout; slave timer_irq never asserts if mtime < 64'h1_00000010.
//  4. ready held 0 after the first req -> req drops after 16 cycles, rsp_valid = 1, rsp_err = 1,
//     cmd_ready = 1 next.
//  5. rst pulsed after the WR_LO_MAX transfer -> req = 0 asynchronously, no rsp_valid,
//     cmd_ready = 1 after release.
//  6. Slave hi increments on every read -> 1 + MAX_RETRY(4) hi-lo-hi rounds, rsp_err = 1,
//     rsp_data = {last hi, last lo}.

Source files
------------

// File: rtl/mtime_bus_master.sv
// Bus initiator for the timer slave port: tear-free 64-bit mtime reads (hi-lo-hi with retry)
// and glitch-free 64-bit mtimecmp writes (lo=max, hi, lo) over a 32-bit req/ready bus.
module mtime_bus_master #(
   parameter logic [31:0] MTIME_ADDR    = 32'h0200BFF8,
   parameter logic [31:0] MTIMECMP_ADDR = 32'h02004000,
   parameter int          MAX_RETRY     = 4,
   parameter int          TIMEOUT       = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_op,
   input  logic [63:0] cmd_wdata,
   output logic        rsp_valid,
   output logic [63:0] rsp_data,
   output logic        rsp_err,
   output logic        req,
   output logic [31:0] addr,
   output logic        we,
   output logic [31:0] wdata,
   input  logic [31:0] rdata,
   input  logic        ready
);

   localparam int RTW = $clog2(MAX_RETRY + 1);
   localparam int TOW = $clog2(TIMEOUT + 1);
   localparam logic [31:0] MTIME_HI    = MTIME_ADDR + 32'd4;
   localparam logic [31:0] MTIMECMP_HI = MTIMECMP_ADDR + 32'd4;

   typedef enum logic [2:0] {
      IDLE,
      RD_HI1,
      RD_LO,
      RD_HI2,
      WR_LO_MAX,
      WR_HI,
      WR_LO
   } state_t;

   state_t          r_state, w_nxt_state;
   logic            r_req, w_nxt_req;
   logic [31:0]     r_addr, w_nxt_addr;
   logic            r_we, w_nxt_we;
   logic [31:0]     r_wdata, w_nxt_wdata;
   logic            r_rsp_valid, w_nxt_rsp_valid;
   logic [63:0]     r_rsp_data, w_nxt_rsp_data;
   logic            r_rsp_err, w_nxt_rsp_err;
   logic [RTW-1:0]  r_retry, w_nxt_retry;
   logic [TOW-1:0]  r_tmo, w_nxt_tmo;
   logic [31:0]     r_hi1, w_nxt_hi1;
   logic [31:0]     r_lo, w_nxt_lo;
   logic [31:0]     r_cmd_hi, w_nxt_cmd_hi;
   logic [31:0]     r_cmd_lo, w_nxt_cmd_lo;

   logic            w_done;
   logic            w_timeout;

   assign w_done    = r_req && ready;
   assign w_timeout = r_req && !ready && (r_tmo == TOW'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_req       <= 1'b0;
         r_addr      <= '0;
         r_we        <= 1'b0;
         r_wdata     <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_err   <= 1'b0;
         r_retry     <= '0;
         r_tmo       <= '0;
         r_hi1       <= '0;
         r_lo        <= '0;
         r_cmd_hi    <= '0;
         r_cmd_lo    <= '0;
      end else begin
         r_state     <= w_nxt_state;
         r_req       <= w_nxt_req;
         r_addr      <= w_nxt_addr;
         r_we        <= w_nxt_we;
         r_wdata     <= w_nxt_wdata;
         r_rsp_valid <= w_nxt_rsp_valid;
         r_rsp_data  <= w_nxt_rsp_data;
         r_rsp_err   <= w_nxt_rsp_err;
         r_retry     <= w_nxt_retry;
         r_tmo       <= w_nxt_tmo;
         r_hi1       <= w_nxt_hi1;
         r_lo        <= w_nxt_lo;
         r_cmd_hi    <= w_nxt_cmd_hi;
         r_cmd_lo    <= w_nxt_cmd_lo;
      end
   end

   // Bus outputs are registered; each completed transfer loads the next address in the same edge.
   always_comb begin
      w_nxt_state     = r_state;
      w_nxt_req       = r_req;
      w_nxt_addr      = r_addr;
      w_nxt_we        = r_we;
      w_nxt_wdata     = r_wdata;
      w_nxt_rsp_valid = 1'b0;
      w_nxt_rsp_data  = r_rsp_data;
      w_nxt_rsp_err   = r_rsp_err;
      w_nxt_retry     = r_retry;
      w_nxt_tmo       = r_tmo;
      w_nxt_hi1       = r_hi1;
      w_nxt_lo        = r_lo;
      w_nxt_cmd_hi    = r_cmd_hi;
      w_nxt_cmd_lo    = r_cmd_lo;

      if (r_req && !ready) begin
         w_nxt_tmo = r_tmo + TOW'(1);
      end else if (w_done) begin
         w_nxt_tmo = '0;
      end

      case (r_state)
         IDLE: begin
            if (cmd_valid) begin
               w_nxt_req   = 1'b1;
               w_nxt_tmo   = '0;
               w_nxt_retry = '0;
               if (cmd_op) begin
                  w_nxt_state  = WR_LO_MAX;
                  w_nxt_addr   = MTIMECMP_ADDR;
                  w_nxt_we     = 1'b1;
                  w_nxt_wdata  = 32'hFFFF_FFFF;
                  w_nxt_cmd_hi = cmd_wdata[63:32];
                  w_nxt_cmd_lo = cmd_wdata[31:0];
               end else begin
                  w_nxt_state = RD_HI1;
                  w_nxt_addr  = MTIME_HI;
                  w_nxt_we    = 1'b0;
               end
            end
         end
         RD_HI1: begin
            if (w_done) begin
               w_nxt_hi1   = rdata;
               w_nxt_state = RD_LO;
               w_nxt_addr  = MTIME_ADDR;
            end
         end
         RD_LO: begin
            if (w_done) begin
               w_nxt_lo    = rdata;
               w_nxt_state = RD_HI2;
               w_nxt_addr  = MTIME_HI;
            end
         end
         RD_HI2: begin
            if (w_done) begin
               if (rdata == r_hi1) begin
                  w_nxt_state     = IDLE;
                  w_nxt_req       = 1'b0;
                  w_nxt_rsp_valid = 1'b1;
                  w_nxt_rsp_data  = {r_hi1, r_lo};
                  w_nxt_rsp_err   = 1'b0;
               end else if (r_retry < RTW'(MAX_RETRY)) begin
                  // hi moved under us: re-read lo against the newer hi
                  w_nxt_hi1   = rdata;
                  w_nxt_retry = r_retry + RTW'(1);
                  w_nxt_state = RD_LO;
                  w_nxt_addr  = MTIME_ADDR;
               end else begin
                  w_nxt_state     = IDLE;
                  w_nxt_req       = 1'b0;
                  w_nxt_rsp_valid = 1'b1;
                  w_nxt_rsp_data  = {rdata, r_lo};
                  w_nxt_rsp_err   = 1'b1;
               end
            end
         end
         WR_LO_MAX: begin
            if (w_done) begin
               w_nxt_state = WR_HI;
               w_nxt_addr  = MTIMECMP_HI;
               w_nxt_wdata = r_cmd_hi;
            end
         end
         WR_HI: begin
            if (w_done) begin
               w_nxt_state = WR_LO;
               w_nxt_addr  = MTIMECMP_ADDR;
               w_nxt_wdata = r_cmd_lo;
            end
         end
         WR_LO: begin
            if (w_done) begin
               w_nxt_state     = IDLE;
               w_nxt_req       = 1'b0;
               w_nxt_we        = 1'b0;
               w_nxt_rsp_valid = 1'b1;
               w_nxt_rsp_err   = 1'b0;
            end
         end
         default: begin
            w_nxt_state = IDLE;
            w_nxt_req   = 1'b0;
            w_nxt_we    = 1'b0;
         end
      endcase

      // A stalled slave aborts the whole sequence; rsp_data keeps its last value.
      if (w_timeout) begin
         w_nxt_state     = IDLE;
         w_nxt_req       = 1'b0;
         w_nxt_we        = 1'b0;
         w_nxt_tmo       = '0;
         w_nxt_rsp_valid = 1'b1;
         w_nxt_rsp_err   = 1'b1;
      end
   end

   assign cmd_ready = (r_state == IDLE);
   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;
   assign rsp_err   = r_rsp_err;
   assign req       = r_req;
   assign addr      = r_addr;
   assign we        = r_we;
   assign wdata     = r_wdata;

endmodule
